// File: rtl/imc_wb_host_master.sv
// imc_wb_host_master: Wishbone classic single-transfer initiator with a command FIFO and timeout.
// Latency: command pushed at edge k drives cyc/stb from edge k+1; response valid at the ack edge.
// Backpressure: cmd_ready=!full (registered count); a response is held until rsp_ready, no new cycle meanwhile.
//
// Ports:
//   wb_clk_i / wb_rst_i        clock, asynchronous active-high reset
//   cmd_*                      command push side (valid/ready), we/addr/data/sel
//   rsp_*                      response pop side (valid/ready), data/err
//   wbm_*                      Wishbone classic master interface (all outputs registered)
//   busy                       FIFO non-empty or a transfer/response in progress
module imc_wb_host_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                busy
);

  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W + SEL_W;
  // Last counter value of a waiting REQ; the abort happens at the edge ending that cycle,
  // so cyc/stb stay high exactly TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  // Command storage, entry layout {we, addr, data, sel}. Contents need no reset.
  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              full, empty, push, pop, launch;
  logic [ENT_W-1:0]  head;
  logic              head_we;
  logic [ADDR_W-1:0] head_adr;
  logic [DATA_W-1:0] head_dat;
  logic [SEL_W-1:0]  head_sel;

  // Full is judged on the registered count only: a pop in the same cycle does not free a slot early.
  assign full  = (count_q == CNT_W'(CMD_DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;

  assign head     = fifo_mem[rd_ptr_q];
  assign head_we  = head[ENT_W-1];
  assign head_adr = head[ENT_W-2 -: ADDR_W];
  assign head_dat = head[SEL_W +: DATA_W];
  assign head_sel = head[SEL_W-1:0];

  // A new transfer starts from IDLE, or directly at the edge that retires the previous response.
  assign launch = !empty && ((state_q == IDLE) || ((state_q == RSP) && rsp_ready));
  assign pop    = launch;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      REQ: begin
        if (wbm_ack_i) begin
          // Ack wins even in the cycle the timeout would expire.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    if (launch) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = head_we;
      adr_d   = head_adr;
      dat_d   = head_dat;
      sel_d   = head_sel;
      tmo_d   = '0;
      state_d = REQ;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_data, cmd_sel};
    end
  end

  assign cmd_ready = !full;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign busy      = !empty || (state_q != IDLE);

endmodule
